// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and helpers for the hazard controller: FSM state type,
// counter-width helper and the hardwired-zero register constant.
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LD_STALL = 1'b1
  } state_e;

  localparam int REG_ZERO = 0;

  // Width needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID/EX hazard bus between the pipeline (master) and the hazard controller (slave).
// Perf-counter outputs exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_is_md;
  logic              id_uses_hilo;
  logic [REG_AW-1:0] ex_wr_addr;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              pc_we;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              stall;
  logic              md_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
`endif

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_uses_hilo,
    output ex_wr_addr, ex_mem_read, ex_branch_taken,
    input  pc_we, if_id_we, if_id_flush, id_ex_bubble, stall, md_busy
`ifdef HAZARD_PERF_CNT_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_md, id_uses_hilo,
    input  ex_wr_addr, ex_mem_read, ex_branch_taken,
    output pc_we, if_id_we, if_id_flush, id_ex_bubble, stall, md_busy
`ifdef HAZARD_PERF_CNT_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_ctrl_unit_md_busy_tracker.sv
// Mul/div occupancy tracker: a start loads MD_CYCLES, then counts down to
// zero; busy while nonzero. A start on the cycle the count hits zero reloads.
module md_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  output logic o_busy
);

  localparam int MD_CW = cnt_w(MD_CYCLES);

  logic [MD_CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= MD_CW'(MD_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / mul-div hazard controller for the 5-stage MIPS pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int LD_STALL_CYCLES = 1,
  parameter int MD_CYCLES       = 4
) (
  input logic               clk,
  input logic               reset,
  hazard_ctrl_unit_if.slave bus
);

  localparam int               LD_CW     = cnt_w(LD_STALL_CYCLES);
  localparam logic [LD_CW-1:0] LD_RELOAD = LD_CW'(LD_STALL_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LD_CW-1:0] r_ld_cnt;
  logic [LD_CW-1:0] w_ld_cnt_nxt;
  logic             w_ld_haz;
  logic             w_md_haz;
  logic             w_ld_stall;
  logic             w_md_stall;
  logic             w_stall;
  logic             w_branch;
  logic             w_md_start;
  logic             w_md_busy;

  // A single match covers id_rs==id_rt==ex_wr_addr; register 0 never hazards.
  assign w_ld_haz = bus.ex_mem_read &&
                    (bus.ex_wr_addr != REG_AW'(REG_ZERO)) &&
                    ((bus.id_use_rs && (bus.id_rs == bus.ex_wr_addr)) ||
                     (bus.id_use_rt && (bus.id_rt == bus.ex_wr_addr)));

  assign w_md_haz   = w_md_busy && (bus.id_uses_hilo || bus.id_is_md);
  assign w_branch   = bus.ex_branch_taken;
  assign w_ld_stall = !w_branch && ((r_state == LD_STALL) || w_ld_haz);
  assign w_md_stall = !w_branch && !w_ld_stall && w_md_haz;
  assign w_stall    = w_ld_stall || w_md_stall;
  assign w_md_start = bus.id_is_md && !w_stall && !w_branch;

  always_comb begin
    w_state_nxt  = r_state;
    w_ld_cnt_nxt = r_ld_cnt;
    if (w_branch) begin
      w_state_nxt  = IDLE;
      w_ld_cnt_nxt = '0;
    end else if (r_state == LD_STALL) begin
      w_ld_cnt_nxt = r_ld_cnt - 1'b1;
      if (r_ld_cnt == LD_CW'(1)) begin
        w_state_nxt = IDLE;
      end
    end else if (w_ld_haz && (LD_STALL_CYCLES > 1)) begin
      w_state_nxt  = LD_STALL;
      w_ld_cnt_nxt = LD_RELOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ld_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_cnt <= w_ld_cnt_nxt;
    end
  end

  md_busy_tracker #(
    .MD_CYCLES(MD_CYCLES)
  ) u_md_busy_tracker (
    .clk    (clk),
    .reset  (reset),
    .i_start(w_md_start),
    .o_busy (w_md_busy)
  );

  assign bus.pc_we        = !w_stall;
  assign bus.if_id_we     = !w_stall;
  assign bus.if_id_flush  = w_branch;
  assign bus.id_ex_bubble = w_branch || w_stall;
  assign bus.stall        = w_stall;
  assign bus.md_busy      = w_md_busy;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_flush_cnt <= '0;
    end else begin
      if (w_stall)  r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (w_branch) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = r_perf_stall_cnt;
  assign bus.perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised next-generation hazard controller for the 5-stage MIPS pipeline.
- Detects load-use hazards, ignoring register 0 and honouring per-operand use flags.
- Holds multi-cycle load stalls with a counter; tracks a busy multi-cycle mul/div unit and stalls dependent HI/LO readers.
- Applies branch-taken flushes with fixed priority; drives PC, IF/ID and ID/EX control.

Parameters:
- REG_AW, 5, register address width.
- LD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..7).
- MD_CYCLES, 4, mul/div occupancy in cycles after issue (legal 2..63).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- id_rs  input  REG_AW  source register Rs of the instruction in ID.
- id_rt  input  REG_AW  source register Rt of the instruction in ID.
- id_use_rs  input  1  instruction in ID reads Rs.
- id_use_rt  input  1  instruction in ID reads Rt.
- id_is_md  input  1  instruction in ID is mult/div.
- id_uses_hilo  input  1  instruction in ID is mfhi/mflo/mthi/mtlo or mult/div.
- ex_wr_addr  input  REG_AW  destination register of the instruction in EX.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- pc_we  output  1  PC write enable.
- if_id_we  output  1  IF/ID register write enable.
- if_id_flush  output  1  clear IF/ID to nop.
- id_ex_bubble  output  1  load nop into ID/EX.
- stall  output  1  any stall active (pc_we==0).
- md_busy  output  1  mul/div unit occupied.

Behaviour:
- Reset: state=IDLE, ld_cnt=0, md_cnt=0.
  - Outputs after reset: pc_we=1, if_id_we=1, if_id_flush=0, id_ex_bubble=0, stall=0, md_busy=0.
  - Reset mid-stall or mid-mul/div aborts it immediately.
- Load-use detection (combinational): ld_haz = ex_mem_read & (ex_wr_addr!=0) & ((id_use_rs & id_rs==ex_wr_addr) | (id_use_rt & id_rt==ex_wr_addr)).
- md_haz = md_busy & id_uses_hilo. A second mul/div issue also stalls while busy.
- State machine:
  - IDLE: if ld_haz and no branch, stall this cycle (same-cycle Mealy response).
    - If LD_STALL_CYCLES>1, go to LD_STALL and load ld_cnt=LD_STALL_CYCLES-1.
  - LD_STALL: stall held unconditionally, independent of inputs except reset and branch.
    - ld_cnt decrements each cycle; return to IDLE in the cycle ld_cnt reaches 1→0.
    - Total bubbles per hazard = LD_STALL_CYCLES exactly.
- Stall response: pc_we=0, if_id_we=0, id_ex_bubble=1, stall=1.
- Mul/div counter:
  - When id_is_md and ID is not stalled or flushed, md_cnt loads MD_CYCLES on the next edge.
  - md_cnt decrements to 0; md_busy = (md_cnt!=0).
  - Branch flush does not cancel an already-issued mul/div.
- Branch flush response: if_id_flush=1, id_ex_bubble=1, pc_we=1, if_id_we=1, stall=0.
- Priority:
  - reset > ex_branch_taken > load stall (ld_haz or LD_STALL) > md_haz.
  - Branch in LD_STALL or in an ld_haz cycle cancels the stall: next state IDLE, ld_cnt=0.
  - A flushed id_is_md never starts the counter.
- Boundaries:
  - ex_wr_addr==0 never stalls.
  - id_rs==id_rt==ex_wr_addr counts as one hazard.
  - md_cnt reaching 0 and a new issue in the same cycle are legal; the counter reloads.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments each cycle stall=1; perf_flush_cnt increments each cycle if_id_flush=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: no counters and no extra ports.

Decomposition:
- Package hazard_pkg:
  - state enum {IDLE, LD_STALL}.
  - Counter widths derived via $clog2 of LD_STALL_CYCLES and MD_CYCLES.
  - REG_ZERO constant.
- One natural sub-module: md_busy_tracker, holding the mul/div countdown counter with start/busy ports.

Test Plan:
- Load-use basic: ex_mem_read=1, ex_wr_addr=8, id_rs=8, id_use_rs=1, LD_STALL_CYCLES=1 → stall=1, pc_we=0, id_ex_bubble=1 for exactly 1 cycle, then pc_we=1.
- Multi-cycle load stall: LD_STALL_CYCLES=3, same hazard held 1 cycle → stall=1 for 3 consecutive cycles regardless of later inputs.
- Register 0 and use flags: ex_wr_addr=0 with matching id_rs=0, and ex_wr_addr=9 with id_rt=9 but id_use_rt=0 → stall stays 0.
- Mul/div: issue id_is_md, MD_CYCLES=4 → md_busy=1 for 4 cycles; mflo (id_uses_hilo=1) in cycle 2 stalls until md_busy falls, then proceeds.
- Branch priority: branch_taken asserted in the 2nd cycle of a 3-cycle load stall → if_id_flush=1, stall=0 that cycle, state IDLE after.
- Reset mid-operation: reset during LD_STALL with md_busy=1 → next cycle all outputs at reset values.
